// File: rtl/tero_response_averager.sv
// TERO response averager: counts oscillation edges of the selected loop per
// enable window, accumulates across repetitions, stores a per-loop average
// and compares loop pairs into PUF response bits when the controller is done.
//
// state   | meaning
// IDLE    | waiting; ready to the controller
// EVAL    | evaluation windows of a loop in progress
// WRITE   | store average of the finished loop into the table
// COMPARE | pairwise compare of table entries into response bits
module tero_response_averager #(
  parameter int NUM_LOOPS        = 4,
  parameter int CNT_BITS         = 16,
  parameter int REPETITIONS_BITS = 16,
  parameter int SEL_BITS         = $clog2(NUM_LOOPS-1)+1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tero_in,
  input  logic                   reset_puf,
  input  logic                   enable_puf,
  input  logic                   store_response_puf,
  input  logic [SEL_BITS-1:0]    select_puf,
  input  logic                   done,
  output logic                   next_enable,
  output logic [CNT_BITS-1:0]    avg_value,
  output logic                   avg_valid,
  output logic [NUM_LOOPS/2-1:0] response,
  output logic                   response_valid
);

  localparam int ACC_BITS = CNT_BITS + REPETITIONS_BITS;
  localparam int IDX_BITS = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
  localparam int HALF     = NUM_LOOPS / 2;
  localparam logic [SEL_BITS:0] LP_NUM_LOOPS = (SEL_BITS+1)'(NUM_LOOPS);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WRITE, S_COMPARE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_next_enable;

  logic                  r_sync1, r_sync2, r_sync3, r_edge_p;
  logic                  r_enable_d, r_done_d, r_done_pend;
  logic [SEL_BITS-1:0]   r_sel_q;
  logic [CNT_BITS-1:0]   r_win;
  logic [ACC_BITS-1:0]   r_acc;
  logic [CNT_BITS-1:0]   r_table [NUM_LOOPS];
  logic [CNT_BITS-1:0]   r_avg_value;
  logic                  r_avg_valid;
  logic [HALF-1:0]       r_response;
  logic                  r_response_valid;

  logic                  w_fold, w_done_rise, w_cmp_req, w_store_go, w_sel_ok;
  logic [ACC_BITS-1:0]   w_acc_fold;
  logic [CNT_BITS-1:0]   w_avg;

  assign w_fold      = r_enable_d & ~enable_puf;
  assign w_done_rise = done & ~r_done_d;
  assign w_cmp_req   = w_done_rise | r_done_pend;
  assign w_store_go  = store_response_puf & ((r_state == S_IDLE) | (r_state == S_EVAL));
  assign w_acc_fold  = r_acc + {{REPETITIONS_BITS{1'b0}}, r_win};
  // acc >> (REPETITIONS_BITS-1), truncated to CNT_BITS
  assign w_avg       = r_acc[REPETITIONS_BITS-1 +: CNT_BITS];
  assign w_sel_ok    = ({1'b0, r_sel_q} < LP_NUM_LOOPS);

  // Synchronize tero_in and detect its rising edge (fixed 3-cycle lag)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_edge_p <= 1'b0;
    end else begin
      r_sync1  <= tero_in;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_edge_p <= r_sync2 & ~r_sync3;
    end
  end

  // Window counter and accumulator; reset_puf beats fold and increment
  always_ff @(posedge clk) begin
    if (reset || reset_puf) begin
      r_win <= '0;
      r_acc <= '0;
    end else begin
      if (w_fold)
        r_win <= '0;
      else if (enable_puf && r_edge_p && !(&r_win))
        r_win <= r_win + CNT_BITS'(1);
      if (r_state == S_WRITE)
        r_acc <= '0;
      else if (w_fold)
        r_acc <= w_acc_fold;
    end
  end

  // Input history, pending compare request and latched loop select
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable_d  <= 1'b0;
      r_done_d    <= 1'b0;
      r_done_pend <= 1'b0;
      r_sel_q     <= '0;
    end else begin
      r_enable_d <= enable_puf;
      r_done_d   <= done;
      if (w_state_nxt == S_COMPARE)
        r_done_pend <= 1'b0;
      else if (w_done_rise)
        r_done_pend <= 1'b1;
      if (w_store_go)
        r_sel_q <= select_puf;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and ready handshake
  always_comb begin
    w_state_nxt   = r_state;
    w_next_enable = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (store_response_puf) begin
          w_state_nxt   = S_WRITE;
          w_next_enable = 1'b0;
        end else if (w_cmp_req) begin
          w_state_nxt = S_COMPARE;
        end else if (enable_puf && !r_enable_d) begin
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (store_response_puf) begin
          w_state_nxt   = S_WRITE;
          w_next_enable = 1'b0;
        end else if (reset_puf) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        w_next_enable = 1'b0;
        w_state_nxt   = w_cmp_req ? S_COMPARE : S_IDLE;
      end
      S_COMPARE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Average table, average output and pairwise response
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) r_table[i] <= '0;
      r_avg_value      <= '0;
      r_avg_valid      <= 1'b0;
      r_response       <= '0;
      r_response_valid <= 1'b0;
    end else begin
      r_avg_valid <= (r_state == S_WRITE);
      if (r_state == S_WRITE) begin
        r_avg_value <= w_avg;
        if (w_sel_ok)
          r_table[r_sel_q[IDX_BITS-1:0]] <= w_avg;
      end
      if (r_state == S_COMPARE) begin
        for (int i = 0; i < HALF; i++)
          r_response[i] <= (r_table[2*i] > r_table[2*i+1]);
        r_response_valid <= 1'b1;
      end else if (reset_puf && (select_puf == '0)) begin
        r_response_valid <= 1'b0;
      end
    end
  end

  assign next_enable    = w_next_enable;
  assign avg_value      = r_avg_value;
  assign avg_valid      = r_avg_valid;
  assign response       = r_response;
  assign response_valid = r_response_valid;

endmodule

// File: tb/tb_tero_response_averager.sv
// Directed bench for tero_response_averager with a scoreboard of expected
// averages that is drained whenever avg_valid pulses.
module tb_tero_response_averager;

  localparam int NL = 4;
  localparam int CB = 8;
  localparam int RB = 3;
  localparam int SB = $clog2(NL-1)+1;

  logic          clk = 1'b0;
  logic          reset, tero_in, reset_puf, enable_puf, store_response_puf, done;
  logic [SB-1:0] select_puf;
  logic          next_enable, avg_valid, response_valid;
  logic [CB-1:0] avg_value;
  logic [NL/2-1:0] response;

  int n_checks = 0;
  int n_errors = 0;
  int ne_low   = 0;
  int ne_mark  = 0;
  int exp_q[$];

  tero_response_averager #(
    .NUM_LOOPS(NL), .CNT_BITS(CB), .REPETITIONS_BITS(RB), .SEL_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .tero_in(tero_in), .reset_puf(reset_puf),
    .enable_puf(enable_puf), .store_response_puf(store_response_puf),
    .select_puf(select_puf), .done(done), .next_enable(next_enable),
    .avg_value(avg_value), .avg_valid(avg_valid), .response(response),
    .response_valid(response_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard drain and next_enable low-cycle counter
  always @(negedge clk) begin
    if (next_enable === 1'b0) ne_low++;
    if (avg_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("avg_unexpected", 32'(avg_value), 32'hFFFF_FFFF);
      else chk("avg_value", 32'(avg_value), 32'(exp_q.pop_front()));
    end
  end

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int exp_avg(input int a, input int b, input int c, input int d);
    return ((sat(a) + sat(b) + sat(c) + sat(d)) >> 2) & 255;
  endfunction

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      tero_in = 1'b1; tick(2);
      tero_in = 1'b0; tick(2);
    end
  endtask

  task automatic window(input int n, input bit st);
    enable_puf = 1'b1; tick(1);
    edges(n);
    tick(5);
    enable_puf = 1'b0; store_response_puf = st; tick(1);
    store_response_puf = 1'b0;
  endtask

  task automatic start_loop(input int sel);
    reset_puf = 1'b1; select_puf = SB'(sel); tick(1);
    reset_puf = 1'b0;
  endtask

  // Leaves the DUT in its WRITE cycle
  task automatic run_loop(input int sel, input int c0, input int c1, input int c2, input int c3);
    start_loop(sel);
    window(c0, 1'b0); window(c1, 1'b0); window(c2, 1'b0);
    exp_q.push_back(exp_avg(c0, c1, c2, c3));
    ne_mark = ne_low;
    window(c3, 1'b1);
  endtask

  initial begin
    reset = 1'b1; tero_in = 1'b0; reset_puf = 1'b0; enable_puf = 1'b0;
    store_response_puf = 1'b0; done = 1'b0; select_puf = '0;
    tick(3);
    reset = 1'b0; tick(1);
    chk("rst_next_enable", 32'(next_enable), 1);
    chk("rst_avg_valid", 32'(avg_valid), 0);
    chk("rst_avg_value", 32'(avg_value), 0);
    chk("rst_response", 32'(response), 0);
    chk("rst_response_valid", 32'(response_valid), 0);

    // Loop 0: 10,12,14,16 -> 13, ready low for store cycle and WRITE
    run_loop(0, 10, 12, 14, 16); tick(2);
    chk("t1_ne_low_cycles", 32'(ne_low - ne_mark), 2);
    chk("t1_table0", 32'(dut.r_table[0]), 13);
    chk("t1_next_enable", 32'(next_enable), 1);

    // Remaining loops 9,5,5 and pairwise compare
    run_loop(1, 9, 9, 9, 9); tick(2);
    run_loop(2, 5, 5, 5, 5); tick(2);
    run_loop(3, 5, 5, 5, 5); tick(2);
    done = 1'b1; tick(1);
    chk("t2_rv_early", 32'(response_valid), 0);
    tick(1);
    chk("t2_rv", 32'(response_valid), 1);
    chk("t2_response", 32'(response), 2'b01);
    done = 1'b0; tick(2);
    start_loop(0);
    chk("t2_rv_cleared", 32'(response_valid), 0);
    chk("t2_response_kept", 32'(response), 2'b01);

    // Saturating window: 300 edges count as 255
    run_loop(1, 300, 1, 0, 0); tick(2);
    chk("t3_table1", 32'(dut.r_table[1]), 64);

    // Stale windows discarded by reset_puf
    start_loop(0);
    window(40, 1'b0); window(40, 1'b0);
    run_loop(0, 8, 8, 8, 8); tick(2);
    chk("t4_table0", 32'(dut.r_table[0]), 8);

    // Edges while enable_puf is low are ignored
    start_loop(2);
    window(4, 1'b0); edges(5); tick(6);
    window(4, 1'b0); edges(5); tick(6);
    window(4, 1'b0);
    exp_q.push_back(4);
    window(4, 1'b1); tick(2);
    chk("t5_table2", 32'(dut.r_table[2]), 4);

    // done rises during WRITE; compare sees the new entry (8,64,4,2 -> 2'b10)
    run_loop(3, 2, 2, 2, 2);
    done = 1'b1; tick(1);
    chk("t6_rv_early", 32'(response_valid), 0);
    tick(1);
    chk("t6_rv", 32'(response_valid), 1);
    chk("t6_response", 32'(response), 2'b10);
    done = 1'b0; tick(2);

    // Reset in the middle of an evaluation window
    start_loop(1);
    enable_puf = 1'b1; tick(1);
    edges(3);
    reset = 1'b1; tick(1);
    chk("t5_rst_next_enable", 32'(next_enable), 1);
    chk("t5_rst_rv", 32'(response_valid), 0);
    chk("t5_rst_response", 32'(response), 0);
    chk("t5_rst_avg_value", 32'(avg_value), 0);
    for (int i = 0; i < NL; i++)
      chk($sformatf("t5_rst_table%0d", i), 32'(dut.r_table[i]), 0);
    reset = 1'b0; enable_puf = 1'b0; tick(3);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tero_response_averager.md
Name: tero_response_averager

Overview:
- Downstream consumer of the TERO evaluation controller.
- Counts oscillation edges of the selected TERO loop during each enable window and accumulates them over all repetitions.
- When the controller requests a store, writes the per-loop average into an internal table. When the controller reports done, compares loop pairs and presents the PUF response bits.
- Drives next_enable back to the controller as its ready handshake.

Parameters:
NUM_LOOPS, 4, number of TERO loops; must be even.
CNT_BITS, 16, width of per-window edge counter and of each stored average.
REPETITIONS_BITS, 16, controller repetition-counter width; windows per loop = 2**(REPETITIONS_BITS-1).
SEL_BITS, $clog2(NUM_LOOPS-1)+1, width of select_puf (matches controller).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tero_in  in  1  oscillation output of the selected loop; asynchronous to clk
reset_puf  in  1  clears window counter and accumulator (start of a loop)
enable_puf  in  1  high during an evaluation window
store_response_puf  in  1  final window of the current loop ends this cycle
select_puf  in  SEL_BITS  index of the loop being evaluated
done  in  1  controller finished all loops
next_enable  out  1  ready to the controller
avg_value  out  CNT_BITS  last average written
avg_valid  out  1  one-cycle pulse when avg_value is updated
response  out  NUM_LOOPS/2  PUF response bits
response_valid  out  1  response holds a complete result

Behaviour:
- Reset (clk edge with reset=1): all counters, accumulator, average table, avg_value, response = 0. avg_valid = 0, response_valid = 0, next_enable = 1. Reset overrides every other input, including mid-window and mid-write.
- Input conditioning: tero_in passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized value, giving edge_p. This adds 3 cycles of fixed lag; the lag is accepted and not compensated.
- Window counter win (CNT_BITS):
  - increments on edge_p when enable_puf=1;
  - saturates at all-ones;
  - edges while enable_puf=0 are ignored.
- Fold: in the cycle where enable_d=1 and enable_puf=0, acc <= acc + win and win <= 0. acc is CNT_BITS+REPETITIONS_BITS wide and cannot overflow.
- reset_puf=1: win <= 0 and acc <= 0. This takes priority over fold and increment in the same cycle.
- FSM states:
  - IDLE: next_enable=1.
  - EVAL: entered on enable_puf rising. Counts edges. On a fold cycle with store_response_puf=0, stays in EVAL; the controller re-enables one cycle later. On a fold cycle with store_response_puf=1, latches sel_q=select_puf, next_enable=0, goes to WRITE.
  - WRITE (1 cycle): table[sel_q] <= acc_total >> (REPETITIONS_BITS-1), truncated to CNT_BITS; acc_total includes the final folded window. Also in WRITE: avg_value <= same value, avg_valid=1, acc <= 0, next_enable=0. If sel_q >= NUM_LOOPS, the table write is suppressed; avg_value and avg_valid still update. Goes to IDLE; next_enable returns to 1 the cycle after WRITE.
  - COMPARE (1 cycle): entered from IDLE on done rising (done & !done_d). For each i, response[i] <= (table[2i] > table[2i+1]); a tie gives 0. response_valid <= 1. Goes to IDLE.
- A done rise that coincides with WRITE is remembered and COMPARE runs the cycle after WRITE.
- response_valid clears when reset=1, or when reset_puf=1 with select_puf=0 (new run). response keeps its value until the next COMPARE.
- store_response_puf without a preceding enable window still triggers WRITE using the current acc.

Test Plan:
Parameters for all scenarios: NUM_LOOPS=4, CNT_BITS=8, REPETITIONS_BITS=3, so 4 windows per loop.
1. reset_puf, then loop 0 with windows of 10, 12, 14, 16 edges; store on the last fall -> avg_value=13, avg_valid pulse, table[0]=13; next_enable low for exactly 2 cycles (store cycle and WRITE).
2. Full run with loop averages 13, 9, 5, 5, then done rise -> response=2'b01 (bit0: 13>9; bit1: 5 vs 5 tie gives 0); response_valid=1 two cycles after done rises. Next reset_puf with select_puf=0 -> response_valid=0 and response still 2'b01.
3. 300 edges in one window -> win saturates at 255; the fold adds 255.
4. Windows of 40 and 40, then reset_puf, then 4 windows of 8 and store -> avg_value=8.
5. Edges toggled while enable_puf=0 between windows -> counts unchanged. reset asserted mid-EVAL -> next_enable=1, response_valid=0, table entries 0 on the following cycle.
6. done rise in the same cycle as WRITE -> COMPARE occurs the next cycle, and the response uses the just-written average.
